// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment vectors are active-low with bit order a..g = [6:0] (seg[6]=a, seg[0]=g).
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_ctrl_hex7seg_decode.sv
// Combinational hex nibble to active-low common-anode segment pattern (a..g = [6:0]).
module hex7seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Full hex table; anything unresolved falls through to a blank digit.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with guard interval and frame-aligned double buffering.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks digits above the most-significant non-zero nibble.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic [4*NUM_DIGITS-1:0]           data_in,
  input  logic                              load,
  output logic                              ready,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [6:0]                        seg,
  output logic [$clog2(NUM_DIGITS)-1:0]     digit_idx,
  output logic                              frame_done
);

  localparam int DW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]         GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0]         SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]         DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  scan_state_e             state_r;
  logic [CW-1:0]           cnt_r;
  logic [DW-1:0]           digit_r;
  logic [4*NUM_DIGITS-1:0] display_r;
  logic [4*NUM_DIGITS-1:0] pending_r;
  logic                    slot_end_s;
  logic                    boundary_s;
  logic [3:0]              nibble_s;
  logic [6:0]              dec_seg_s;
  logic                    blank_s;

  assign slot_end_s = (state_r == DRIVE) && (cnt_r == SLOT_LAST);
  assign boundary_s = enable && slot_end_s && (digit_r == DIGIT_LAST);
  assign nibble_s   = display_r[{digit_r, 2'b00} +: 4];

  hex7seg_decode u_decode (
    .nibble (nibble_s),
    .seg    (dec_seg_s)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [DW-1:0] msd_s;

  // Highest non-zero digit; digit 0 is the floor so an all-zero value still shows "0".
  always_comb begin
    msd_s = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      msd_s = (display_r[4*k +: 4] != 4'h0) ? DW'(k) : msd_s;
    end
  end

  assign blank_s = (digit_r > msd_s);
`else
  assign blank_s = 1'b0;
`endif

  // Slot sequencer: one slot counter spans guard then drive; dropping enable always restarts at digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      digit_r <= '0;
    end else if (!enable) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      digit_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= GUARD;
          cnt_r   <= '0;
          digit_r <= '0;
        end
        GUARD: begin
          state_r <= (cnt_r == GUARD_LAST) ? DRIVE : GUARD;
          cnt_r   <= cnt_r + CW'(1);
        end
        DRIVE: begin
          if (slot_end_s) begin
            state_r <= GUARD;
            cnt_r   <= '0;
            digit_r <= (digit_r == DIGIT_LAST) ? '0 : digit_r + DW'(1);
          end else begin
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          digit_r <= '0;
        end
      endcase
    end
  end

  // Double buffer: a held pending value moves to display only at a frame boundary or while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_r <= '0;
      pending_r <= '0;
      ready     <= 1'b1;
    end else if (!ready && ((state_r == IDLE) || boundary_s)) begin
      display_r <= pending_r;
      ready     <= 1'b1;
    end else if (load && ready) begin
      pending_r <= data_in;
      ready     <= 1'b0;
    end else begin
      pending_r <= pending_r;
      ready     <= ready;
    end
  end

  // Registered pin drivers, one cycle behind the sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary_s;
      digit_idx  <= enable ? digit_r : '0;
      if (enable && (state_r == DRIVE)) begin
        an  <= ~(AN_ONE << digit_r);
        seg <= blank_s ? SEG_BLANK : dec_seg_s;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule
